// File: rtl/comp_search_pkg.sv
// Shared definitions for comparator-side logic: search state encoding and
// the flag sanity check that future comparator checkers reuse.
package comp_search_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    // A well-behaved comparator asserts exactly one of its three flags.
    function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
        return (eq & ~gt & ~lt) | (~eq & gt & ~lt) | (~eq & ~gt & lt);
    endfunction

endpackage

// File: rtl/comp_search.sv
// Binary-search controller: drives a probe onto an external magnitude
// comparator and converges on the unknown value at the comparator's B port.
module comp_search
    import comp_search_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [WIDTH-1:0]              A,
    input  logic                          AeqB,
    input  logic                          AgtB,
    input  logic                          AltB,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [WIDTH-1:0]              result,
    output logic                          err,
    output logic [$clog2(WIDTH+2)-1:0]    probes
);

    localparam int PW = $clog2(WIDTH+2);
    localparam logic [WIDTH:0]  HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [PW-1:0]   MAX_PROBES = PW'(WIDTH + 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH:0]    lo_q, lo_d;
    logic [WIDTH:0]    hi_q, hi_d;
    logic [PW-1:0]     probes_q, probes_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    nlo, nhi;
    logic              issue;
    logic              fail;

    // Bounds never exceed 2^WIDTH-1, so the WIDTH+1 bit sum cannot overflow.
    function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] lo, input logic [WIDTH:0] hi);
        logic [WIDTH:0] sum;
        sum = lo + hi;
        return sum[WIDTH:1];
    endfunction

    assign a_ext = {1'b0, a_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probes_d = probes_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;
        nlo      = lo_q;
        nhi      = hi_q;
        issue    = 1'b0;
        fail     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = HI_INIT;
                    a_d      = midpoint('0, HI_INIT);
                    probes_d = PW'(1);
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!flags_onehot(AeqB, AgtB, AltB)) begin
                    fail = 1'b1;
                end else if (AeqB) begin
                    result_d = a_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (AgtB) begin
                    if (a_ext == lo_q) begin
                        fail = 1'b1;
                    end else begin
                        nhi   = a_ext - (WIDTH+1)'(1);
                        issue = 1'b1;
                    end
                end else begin
                    if (a_ext == hi_q) begin
                        fail = 1'b1;
                    end else begin
                        nlo   = a_ext + (WIDTH+1)'(1);
                        issue = 1'b1;
                    end
                end

                // Probe-count guard keeps an inconsistent comparator from looping.
                if (issue) begin
                    if (probes_q >= MAX_PROBES) begin
                        fail = 1'b1;
                    end else begin
                        lo_d     = nlo;
                        hi_d     = nhi;
                        a_d      = midpoint(nlo, nhi);
                        probes_d = probes_q + PW'(1);
                    end
                end

                if (fail) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            probes_q <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probes_q <= probes_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign A      = a_q;
    assign busy   = (state_q == S_SEARCH);
    assign done   = done_q;
    assign found  = found_q;
    assign result = result_q;
    assign err    = err_q;
    assign probes = probes_q;

endmodule

// File: tb/tb_comp_search.sv
// Bench for comp_search: behavioural comparator as target, scoreboard of
// expected search outcomes popped when done pulses.
module tb_comp_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rst;
    logic       start8, start2;
    logic [7:0] b8;
    logic [1:0] b2;
    logic [1:0] mode;

    logic [7:0] a8, result8;
    logic [3:0] probes8;
    logic       eq8, gt8, lt8, busy8, done8, found8, err8;
    logic [1:0] a2, result2, probes2;
    logic       eq2, gt2, lt2, busy2, done2, found2, err2;

    // Comparator model; mode 1 forces eq+gt, mode 2 forces gt constantly.
    always_comb begin
        case (mode)
            2'd1:    {eq8, gt8, lt8} = 3'b110;
            2'd2:    {eq8, gt8, lt8} = 3'b010;
            default: {eq8, gt8, lt8} = {a8 == b8, a8 > b8, a8 < b8};
        endcase
    end
    assign eq2 = (a2 == b2);
    assign gt2 = (a2 > b2);
    assign lt2 = (a2 < b2);

    comp_search #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8),
        .AeqB(eq8), .AgtB(gt8), .AltB(lt8),
        .busy(busy8), .done(done8), .found(found8), .result(result8),
        .err(err8), .probes(probes8)
    );

    comp_search #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2),
        .AeqB(eq2), .AgtB(gt2), .AltB(lt2),
        .busy(busy2), .done(done2), .found(found2), .result(result2),
        .err(err2), .probes(probes2)
    );

    typedef struct {
        logic       found;
        logic       err;
        logic [7:0] result;
        int         probes;
        int         start_cyc;
        string      tag;
    } exp_t;

    exp_t       q8[$];
    exp_t       mon_e;
    logic [7:0] aseq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference binary search over integers.
    function automatic exp_t model(input int w, input int b, input int md);
        exp_t r;
        int lo, hi, a;
        r.found = 0; r.err = 0; r.result = 0; r.probes = 0; r.start_cyc = 0; r.tag = "";
        lo = 0;
        hi = (1 << w) - 1;
        for (int p = 1; p <= w + 1; p++) begin
            a = (lo + hi) / 2;
            r.probes = p;
            if (md == 1) begin r.err = 1; return r; end
            if (md == 0 && a == b) begin r.found = 1; r.result = a[7:0]; return r; end
            if (md == 2 || a > b) begin
                if (a == lo) begin r.err = 1; return r; end
                hi = a - 1;
            end else begin
                if (a == hi) begin r.err = 1; return r; end
                lo = a + 1;
            end
        end
        r.err = 1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (busy8) aseq.push_back(a8);
            if (busy8 && done8) check("busy_done_overlap", 32'd1, 32'd0);
            if (done8) begin
                if (q8.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    mon_e = q8.pop_front();
                    check({mon_e.tag, "_found"},   found8,  mon_e.found);
                    check({mon_e.tag, "_err"},     err8,    mon_e.err);
                    check({mon_e.tag, "_result"},  result8, mon_e.result);
                    check({mon_e.tag, "_probes"},  probes8, mon_e.probes);
                    check({mon_e.tag, "_latency"}, cyc - mon_e.start_cyc, mon_e.probes);
                end
            end
        end
    end

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        check({tag, "_timeout"}, q8.size(), 0);
        q8.delete();
        @(negedge clk);
    endtask

    task automatic push_exp(input int b, input int md, input string tag, input int delay);
        exp_t e;
        e = model(8, b, md);
        e.start_cyc = cyc + 1 + delay;
        e.tag = tag;
        q8.push_back(e);
    endtask

    task automatic run8(input int b, input int md, input string tag);
        @(negedge clk);
        b8 = b[7:0];
        mode = md[1:0];
        aseq.delete();
        push_exp(b, md, tag, 0);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check({tag, "_probe1"}, a8, 32'd127);
        wait_empty(tag);
    endtask

    task automatic check_seq(input string tag, input int exp[$]);
        check({tag, "_seqlen"}, aseq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < aseq.size(); i++)
            check($sformatf("%s_seq%0d", tag, i), aseq[i], exp[i]);
    endtask

    task automatic run2(input int b);
        exp_t e;
        int   st;
        e = model(2, b, 0);
        @(negedge clk);
        b2 = b[1:0];
        start2 = 1'b1;
        st = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        check($sformatf("w2_b%0d_probe1", b), a2, 32'd1);
        for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
        check($sformatf("w2_b%0d_done", b), done2, 32'd1);
        check($sformatf("w2_b%0d_found", b), found2, e.found);
        check($sformatf("w2_b%0d_result", b), result2, b);
        check($sformatf("w2_b%0d_probes", b), probes2, e.probes);
        check($sformatf("w2_b%0d_latency", b), cyc - st, e.probes);
    endtask

    initial begin
        int seq0[$];
        int seq255[$];
        seq0   = '{127, 63, 31, 15, 7, 3, 1, 0};
        seq255 = '{127, 191, 223, 239, 247, 251, 253, 254, 255};

        rst = 1'b1; start8 = 1'b0; start2 = 1'b0; b8 = '0; b2 = '0; mode = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_A", a8, 0);
        check("rst_busy_done", {busy8, done8}, 0);
        check("rst_found_err", {found8, err8}, 0);
        check("rst_result", result8, 0);
        check("rst_probes", probes8, 0);
        rst = 1'b0;
        @(negedge clk);

        run8(127, 0, "b127");
        run8(0, 0, "b0");
        check_seq("b0", seq0);
        run8(255, 0, "b255");
        check_seq("b255", seq255);
        run8(200, 0, "b200");
        run8(1, 0, "b1");
        run8(63, 1, "eqgt");
        run8(63, 2, "allgt");

        // Reset during the third cycle of a B=0 search.
        @(negedge clk);
        b8 = 8'd0; mode = 2'd0;
        push_exp(0, 0, "rstmid", 0);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        q8.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_A", a8, 0);
        check("rstmid_busy_done", {busy8, done8}, 0);
        check("rstmid_found_err", {found8, err8}, 0);
        check("rstmid_result_probes", {result8, probes8}, 0);
        @(negedge clk);
        rst = 1'b0;
        run8(0, 0, "after_rst");

        // Start pulsed while busy must not restart the search.
        @(negedge clk);
        b8 = 8'd255; mode = 2'd0;
        push_exp(255, 0, "busy_start", 0);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_empty("busy_start");

        // Start held through the done cycle launches a second search.
        @(negedge clk);
        b8 = 8'd127; mode = 2'd0;
        push_exp(127, 0, "b2b_first", 0);
        push_exp(127, 0, "b2b_second", 2);
        start8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0;
        wait_empty("b2b");

        for (int b = 0; b < 4; b++) run2(b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
